// File: rtl/replica_pkg.sv
// replica_pkg: shared replica command types, sequencer states and the xorshift32 step
package replica_pkg;
  typedef enum logic [1:0] {NOP, PREV, FOLW, SELF} exchange_command_t;
  typedef enum logic [1:0] {OR0, OR1, THR} opt_command_t;
  typedef enum logic [2:0] {IDLE, DECIDE, COPY, NEXT, DONE} seq_state_t;
  function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    return y ^ (y << 5);
  endfunction
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'd0) ? 32'h1 : s;
  endfunction
endpackage

// File: rtl/xorshift32.sv
// xorshift32: seedable 32-bit xorshift generator, advanced one step per step pulse
module xorshift32
  import replica_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] out
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) out <= 32'h1;
    else if (load) out <= seed_fix(seed);
    else if (step) out <= xorshift32_step(out);
endmodule

// File: rtl/exchange_sequencer.sv
// exchange_sequencer: sequences replica exchange rounds (decide, copy city words, advance RNG)
module exchange_sequencer
  import replica_pkg::*;
#(
  parameter int city_num    = 30,
  parameter int replica_num = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
  input  logic [15:0]                 rounds,
  input  logic [31:0]                 seed,
  output opt_command_t                opt_command,
  output exchange_command_t           exch_command,
  output logic [31:0]                 r_exchange,
  output logic                        word_valid,
  output logic [$clog2(city_num)-1:0] word_addr,
  output logic                        busy,
  output logic                        done
);
  localparam int AW = $clog2(city_num);
  if (city_num < 2 || replica_num < 1) begin : g_param_check
    $error("exchange_sequencer: city_num must be >= 2 and replica_num >= 1");
  end
  seq_state_t  r_state, w_next;
  logic [15:0] r_round_cnt, r_rounds;
  logic        r_parity, r_stop;
  logic [AW-1:0] r_addr;
  logic [31:0] w_rng;
  logic        w_accept, w_last_word, w_final, w_active;
  assign w_accept    = start && (r_state == IDLE);
  assign w_last_word = (r_addr == AW'(city_num - 1));
  assign w_final     = (r_round_cnt + 16'd1 == r_rounds) || r_stop;
  xorshift32 u_rng (
    .clk  (clk),
    .reset(reset),
    .load (w_accept),
    .seed (seed),
    .step (r_state == NEXT),
    .out  (w_rng)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (rounds == 16'd0) ? DONE : DECIDE;
      DECIDE:  w_next = COPY;
      COPY:    if (w_last_word) w_next = NEXT;
      NEXT:    w_next = w_final ? DONE : DECIDE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_active     = (r_state == DECIDE) || (r_state == COPY);
    busy         = (r_state != IDLE);
    done         = (r_state == DONE);
    word_valid   = (r_state == COPY);
    word_addr    = word_valid ? r_addr : '0;
    opt_command  = w_active ? (r_parity ? OR1 : OR0) : THR;
    exch_command = w_active ? SELF : NOP;
  end
  // r_exchange is loaded with the value the RNG holds on entry to each DECIDE
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_round_cnt <= '0;
      r_rounds    <= '0;
      r_parity    <= 1'b0;
      r_stop      <= 1'b0;
      r_addr      <= '0;
      r_exchange  <= '0;
    end else begin
      if (w_accept) begin
        r_rounds    <= rounds;
        r_round_cnt <= '0;
        r_parity    <= 1'b0;
        r_exchange  <= seed_fix(seed);
      end
      if (r_state == NEXT) begin
        r_round_cnt <= r_round_cnt + 16'd1;
        r_parity    <= ~r_parity;
        r_exchange  <= xorshift32_step(w_rng);
      end
      r_addr <= (r_state == COPY && !w_last_word) ? r_addr + 1'b1 : '0;
      r_stop <= (r_state == IDLE || r_state == DONE) ? 1'b0 : (r_stop | stop);
    end
endmodule
